// File: rtl/bitselect_pkg.sv
// Shared constants and types for the bitselect select unit.
package bitselect_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned IDX_W  = $clog2(WORD_W);

    localparam logic signed [WORD_W-1:0] NOT_FOUND = -32'sd1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} bitselect_state_t;

    typedef logic [IDX_W-1:0] idx_t;
    // One extra bit so the running count can reach WORD_W.
    typedef logic [IDX_W:0]   cnt_t;

    localparam idx_t IDX_LAST = idx_t'(WORD_W - 1);

    function automatic logic rank_out_of_range(logic [WORD_W-1:0] rank);
        return (rank == '0) || (rank > WORD_W);
    endfunction

    function automatic logic signed [WORD_W-1:0] idx_to_pos(idx_t idx);
        return {{(WORD_W - IDX_W){1'b0}}, idx};
    endfunction

endpackage

// File: rtl/bitselect_launch.sv
// Rising-edge detector on a level start request; one-cycle launch pulse.
module bitselect_launch (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic launch
);

    logic startfollow;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            startfollow <= 1'b0;
        end else begin
            startfollow <= start;
        end
    end

    assign launch = start && !startfollow;

endmodule

// File: rtl/bitselect.sv
// Iterative select: index of the k-th set bit (LSB first), one bit per cycle.
// BITSELECT_EARLY_EXIT_EN: finish on the hit edge instead of always after 32 bits.
module bitselect
    import bitselect_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [WORD_W-1:0]        in,
    input  logic [WORD_W-1:0]        k,
    output logic                     finish,
    output logic signed [WORD_W-1:0] position
);

    logic launch;

    bitselect_launch u_launch (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .launch (launch)
    );

    bitselect_state_t          state_q, state_d;
    idx_t                      i_q, i_d;
    cnt_t                      cnt_q, cnt_d;
    logic [WORD_W-1:0]         in_q, in_d;
    logic [WORD_W-1:0]         k_q, k_d;
    logic                      finish_q, finish_d;
    logic signed [WORD_W-1:0]  position_q, position_d;
    logic                      hit;

`ifndef BITSELECT_EARLY_EXIT_EN
    // Constant-time mode keeps the first hit aside until the scan ends.
    logic found_q, found_d;
    idx_t found_idx_q, found_idx_d;
`endif

    assign hit = in_q[i_q] && ((32'(cnt_q) + 32'd1) == k_q);

    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        cnt_d      = cnt_q;
        in_d       = in_q;
        k_d        = k_q;
        finish_d   = finish_q;
        position_d = position_q;
`ifndef BITSELECT_EARLY_EXIT_EN
        found_d     = found_q;
        found_idx_d = found_idx_q;
`endif
        if (launch) begin
            in_d     = in;
            k_d      = k;
            i_d      = '0;
            cnt_d    = '0;
            finish_d = 1'b0;
            state_d  = SCAN;
`ifndef BITSELECT_EARLY_EXIT_EN
            found_d  = 1'b0;
`endif
        end else if (state_q == SCAN) begin
`ifdef BITSELECT_EARLY_EXIT_EN
            if (rank_out_of_range(k_q)) begin
                position_d = NOT_FOUND;
                finish_d   = 1'b1;
                state_d    = DONE;
            end else if (hit) begin
                position_d = idx_to_pos(i_q);
                finish_d   = 1'b1;
                state_d    = DONE;
            end else begin
                cnt_d = cnt_q + cnt_t'(in_q[i_q]);
                i_d   = i_q + idx_t'(1);
                if (i_q == IDX_LAST) begin
                    position_d = NOT_FOUND;
                    finish_d   = 1'b1;
                    state_d    = DONE;
                end
            end
`else
            if (hit && !found_q) begin
                found_d     = 1'b1;
                found_idx_d = i_q;
            end
            cnt_d = cnt_q + cnt_t'(in_q[i_q]);
            i_d   = i_q + idx_t'(1);
            if (i_q == IDX_LAST) begin
                if (found_q) begin
                    position_d = idx_to_pos(found_idx_q);
                end else if (hit) begin
                    position_d = idx_to_pos(i_q);
                end else begin
                    position_d = NOT_FOUND;
                end
                finish_d = 1'b1;
                state_d  = DONE;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            i_q        <= '0;
            cnt_q      <= '0;
            in_q       <= '0;
            k_q        <= '0;
            finish_q   <= 1'b0;
            position_q <= '0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            cnt_q      <= cnt_d;
            in_q       <= in_d;
            k_q        <= k_d;
            finish_q   <= finish_d;
            position_q <= position_d;
        end
    end

`ifndef BITSELECT_EARLY_EXIT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            found_q     <= 1'b0;
            found_idx_q <= '0;
        end else begin
            found_q     <= found_d;
            found_idx_q <= found_idx_d;
        end
    end
`endif

    assign finish   = finish_q;
    assign position = position_q;

endmodule

// File: tb/tb_bitselect.sv
// Directed and random checks of bitselect against a software select model.
module tb_bitselect;

    logic               clk;
    logic               rst;
    logic               start;
    logic [31:0]        in_w;
    logic [31:0]        k_w;
    logic               finish;
    logic signed [31:0] position;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] pos;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] last_pos = '0;

    bitselect dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in       (in_w),
        .k        (k_w),
        .finish   (finish),
        .position (position)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_pos(logic [31:0] w, logic [31:0] kk);
        int c = 0;
        for (int b = 0; b < 32; b++) begin
            if (w[b]) begin
                c++;
                if (32'(c) == kk) return 32'(b);
            end
        end
        return 32'hFFFF_FFFF;
    endfunction

    function automatic int model_lat(logic [31:0] kk, logic [31:0] pos);
`ifdef BITSELECT_EARLY_EXIT_EN
        if (kk == 0 || kk > 32) return 1;
        if (pos == 32'hFFFF_FFFF) return 32;
        return int'(pos) + 1;
`else
        if (kk == 0 && pos == 0) return 0;
        return 32;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] w, input logic [31:0] kk, input int extra);
        exp_t e;
        e.pos = model_pos(w, kk);
        e.lat = model_lat(kk, e.pos) + extra;
        sb.push_back(e);
    endtask

    // Entered at the negedge right after the launch edge.
    task automatic collect();
        exp_t e;
        int   lat;
        bit   seen;
        check("finish_clear", 32'(finish), 32'd0);
        check("position_kept", position, last_pos);
        seen = 1'b0;
        lat  = 0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            if (finish === 1'b1) begin
                seen = 1'b1;
                lat  = c;
            end
        end
        check("finish_seen", 32'(seen), 32'd1);
        e = sb.pop_front();
        check("latency", 32'(lat), 32'(e.lat));
        check("position", position, e.pos);
        last_pos = e.pos;
    endtask

    task automatic run(input logic [31:0] w, input logic [31:0] kk, input bit hold);
        push_exp(w, kk, 0);
        start = 1'b1;
        in_w  = w;
        k_w   = kk;
        @(negedge clk);
        in_w = $urandom;
        k_w  = $urandom;
        if (!hold) start = 1'b0;
        collect();
        if (hold) begin
            repeat (3) begin
                @(negedge clk);
                check("finish_hold", 32'(finish), 32'd1);
            end
            start = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] kk;

        rst   = 1'b0;
        start = 1'b0;
        in_w  = '0;
        k_w   = '0;
        repeat (2) @(negedge clk);
        check("reset_finish", 32'(finish), 32'd0);
        check("reset_position", position, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        run(32'h0000_00F0, 32'd2, 1'b0);
        run(32'h8000_0000, 32'd1, 1'b0);
        run(32'h0000_0000, 32'd1, 1'b0);
        run(32'hFFFF_FFFF, 32'd0, 1'b1);
        run(32'h0000_0001, 32'd1, 1'b0);
        run(32'hFFFF_FFFF, 32'd32, 1'b0);
        run(32'hFFFF_FFFF, 32'd33, 1'b0);
        run(32'h0000_0003, 32'd2, 1'b0);

        // Abort a scan mid-flight and relaunch at E6.
        start = 1'b1;
        in_w  = 32'h8000_0000;
        k_w   = 32'd1;
        @(negedge clk);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check("abort_finish_low", 32'(finish), 32'd0);
        end
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_finish_low", 32'(finish), 32'd0);
        push_exp(32'h0000_0003, 32'd2, 0);
        start = 1'b1;
        in_w  = 32'h0000_0003;
        k_w   = 32'd2;
        @(negedge clk);
        in_w  = 32'h0;
        k_w   = 32'd5;
        start = 1'b0;
        collect();

        // Asynchronous reset mid-scan.
        start = 1'b1;
        in_w  = 32'h8000_0000;
        k_w   = 32'd1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_rst_finish", 32'(finish), 32'd0);
        check("async_rst_position", position, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        check("idle_after_rst_finish", 32'(finish), 32'd0);
        check("idle_after_rst_position", position, 32'd0);
        last_pos = '0;

        for (int n = 0; n < 200; n++) begin
            case (n % 3)
                0:       w = $urandom & $urandom;
                1:       w = $urandom;
                default: w = $urandom | $urandom;
            endcase
            kk = $urandom_range(0, 34);
            run(w, kk, (n % 50) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
